// File: rtl/ysyx_23060203_axi_sram_resp_if.sv
// AXI4 bus bundle between the core's memory master and the SRAM responder.
// Both modports carry the full AR/R/AW/W/B channel set.
interface ysyx_23060203_axi_sram_resp_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output araddr, arvalid, arlen, rready,
    output awaddr, awvalid, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  araddr, arvalid, arlen, rready,
    input  awaddr, awvalid, awlen, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_23060203_axi_sram_resp.sv
// AXI4 SRAM responder used as NPC main memory: independent read and write burst FSMs.
// Define RAND_DELAY_EN to insert LFSR-driven 0-7 cycle stalls before each ready/valid.
module ysyx_23060203_axi_sram_resp #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_23060203_axi_sram_resp_if.slave  axi
);

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

  logic [31:0] mem [DEPTH];

  rd_state_t   rd_state, rd_next;
  wr_state_t   wr_state, wr_next;
  logic [31:0] rd_addr, wr_addr, fetch_addr;
  logic [7:0]  rd_cnt, wr_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q, wr_err, rd_load;
  logic        rd_go, wr_go;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Wrapped addresses fall below BASE, so they are rejected here as well.
  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE) >> 2);
  endfunction

  assign axi.arready = (rd_state == RD_IDLE) && rd_go;
  assign axi.rvalid  = (rd_state == RD_DATA) && rd_go;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.awready = (wr_state == WR_IDLE) && wr_go;
  assign axi.wready  = (wr_state == WR_DATA) && wr_go;
  assign axi.bvalid  = (wr_state == WR_RESP) && wr_go;
  assign axi.bresp   = wr_err ? SLVERR : OKAY;

  assign ar_hs = axi.arvalid & axi.arready;
  assign r_hs  = axi.rvalid  & axi.rready;
  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid  & axi.wready;
  assign b_hs  = axi.bvalid  & axi.bready;

`ifdef RAND_DELAY_EN
  logic [7:0] lfsr;
  logic [2:0] rd_wait, wr_wait;

  // Each handshake reloads its channel's stall counter from the LFSR.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr    <= 8'hA5;
      rd_wait <= 3'd0;
      wr_wait <= 3'd0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (ar_hs || r_hs)              rd_wait <= lfsr[2:0];
      else if (rd_wait != 3'd0)       rd_wait <= rd_wait - 3'd1;
      if (aw_hs || w_hs || b_hs)      wr_wait <= lfsr[5:3];
      else if (wr_wait != 3'd0)       wr_wait <= wr_wait - 3'd1;
    end
  end

  assign rd_go = (rd_wait == 3'd0);
  assign wr_go = (wr_wait == 3'd0);
`else
  assign rd_go = 1'b1;
  assign wr_go = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (r_hs && rd_cnt == 8'd0) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // rd_cnt counts beats remaining after the one currently presented on R.
  assign fetch_addr = ar_hs ? axi.araddr : rd_addr;
  assign rd_load    = ar_hs || (r_hs && rd_cnt != 8'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_q <= 32'd0;
      rresp_q <= OKAY;
      rlast_q <= 1'b0;
      rd_addr <= 32'd0;
      rd_cnt  <= 8'd0;
    end else if (rd_load) begin
      if (in_range(fetch_addr)) begin
        rdata_q <= mem[word_idx(fetch_addr)];
        rresp_q <= OKAY;
      end else begin
        rdata_q <= 32'hdead_beef;
        rresp_q <= SLVERR;
      end
      rlast_q <= ar_hs ? (axi.arlen == 8'd0) : (rd_cnt == 8'd1);
      rd_cnt  <= ar_hs ? axi.arlen : rd_cnt - 8'd1;
      rd_addr <= fetch_addr + 32'd4;
    end else if (r_hs) begin
      rlast_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (aw_hs) wr_next = WR_DATA;
      WR_DATA: if (w_hs && wr_cnt == 8'd0) wr_next = WR_RESP;
      WR_RESP: if (b_hs) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // A wlast that disagrees with the beat count poisons the response but not the data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_addr <= 32'd0;
      wr_cnt  <= 8'd0;
      wr_err  <= 1'b0;
    end else if (aw_hs) begin
      wr_addr <= axi.awaddr;
      wr_cnt  <= axi.awlen;
      wr_err  <= 1'b0;
    end else if (w_hs) begin
      wr_addr <= wr_addr + 32'd4;
      wr_cnt  <= wr_cnt - 8'd1;
      if (!in_range(wr_addr) || (axi.wlast != (wr_cnt == 8'd0))) wr_err <= 1'b1;
    end
  end

  // Reads sample mem on the same edge, so a colliding read sees the old word.
  always_ff @(posedge clock) begin
    if (w_hs && in_range(wr_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.wstrb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= axi.wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_axi_sram_resp.sv
// Directed self-checking bench for the AXI SRAM responder.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
module tb_ysyx_23060203_axi_sram_resp;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  ysyx_23060203_axi_sram_resp_if bus();

  ysyx_23060203_axi_sram_resp dut (
    .clock (clock),
    .reset (reset),
    .axi   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
    while (!bus.awready && n < 50) begin tick(); n++; end
    if (!bus.awready) begin checks++; fails++; $display("[TB] FAIL aw_timeout: awready=%b required 1", bus.awready); end
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 50) begin tick(); n++; end
    if (!bus.wready) begin checks++; fails++; $display("[TB] FAIL w_timeout: wready=%b required 1", bus.wready); end
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] resp);
    int n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 50) begin tick(); n++; end
    if (!bus.bvalid) begin checks++; fails++; $display("[TB] FAIL b_timeout: bvalid=%b required 1", bus.bvalid); end
    resp = bus.bresp;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (!bus.arready) begin checks++; fails++; $display("[TB] FAIL ar_timeout: arready=%b required 1", bus.arready); end
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic recv_r(output logic [31:0] data, output logic [1:0] resp, output logic last);
    int n = 0;
    bus.rready = 1'b1;
    while (!bus.rvalid && n < 50) begin tick(); n++; end
    if (!bus.rvalid) begin checks++; fails++; $display("[TB] FAIL r_timeout: rvalid=%b required 1", bus.rvalid); end
    data = bus.rdata; resp = bus.rresp; last = bus.rlast;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    send_aw(addr, 8'd0);
    send_w(data, strb, 1'b1);
    recv_b(resp);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: arready=%b awready=%b required 1 1", bus.arready, bus.awready); end
    checks++; if (bus.rvalid !== 1'b0 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: rvalid=%b wready=%b bvalid=%b required 0 0 0", bus.rvalid, bus.wready, bus.bvalid); end
    checks++; if (bus.rlast !== 1'b0 || bus.rresp !== 2'b00 || bus.bresp !== 2'b00 || bus.rdata !== 32'd0) begin fails++; $display("[TB] FAIL reset_data: rlast=%b rresp=%b bresp=%b rdata=%h required 0 00 00 0", bus.rlast, bus.rresp, bus.bresp, bus.rdata); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    logic [1:0] resp;
    send_aw(32'h8000_0000, 8'd0);
    send_w(32'h1234_5678, 4'hF, 1'b1);
    recv_b(resp);
    checks++; if (resp !== 2'b00) begin fails++; $display("[TB] FAIL single_bresp: got %b required 00", resp); end
    send_ar(32'h8000_0000, 8'd0);
    checks++; if (bus.rvalid !== 1'b1) begin fails++; $display("[TB] FAIL single_latency: rvalid=%b required 1", bus.rvalid); end
    checks++; if (bus.rdata !== 32'h1234_5678 || bus.rlast !== 1'b1 || bus.rresp !== 2'b00) begin fails++; $display("[TB] FAIL single_beat: rdata=%h rlast=%b rresp=%b required 12345678 1 00", bus.rdata, bus.rlast, bus.rresp); end
    bus.rready = 1'b1; tick(); bus.rready = 1'b0;
    checks++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin fails++; $display("[TB] FAIL single_done: rvalid=%b arready=%b required 0 1", bus.rvalid, bus.arready); end
  endtask

  task automatic test_burst();
    logic [31:0] d; logic [1:0] resp; logic last;
    send_aw(32'h8000_0100, 8'd3);
    for (int i = 0; i < 4; i++) send_w(32'(i + 1), 4'hF, i == 3);
    recv_b(resp);
    checks++; if (resp !== 2'b00) begin fails++; $display("[TB] FAIL burst_bresp: got %b required 00", resp); end
    send_ar(32'h8000_0100, 8'd3);
    for (int i = 0; i < 4; i++) begin
      recv_r(d, resp, last);
      checks++; if (d !== 32'(i + 1) || last !== (i == 3) || resp !== 2'b00) begin fails++; $display("[TB] FAIL burst_beat%0d: rdata=%h rlast=%b rresp=%b required %h %b 00", i, d, last, resp, 32'(i + 1), i == 3); end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] resp; logic last;
    write_word(32'h8000_0200, 32'h0000_0000, 4'hF);
    write_word(32'h8000_0200, 32'hAABB_CCDD, 4'b0101);
    send_ar(32'h8000_0200, 8'd0);
    recv_r(d, resp, last);
    checks++; if (d !== 32'h00BB_00DD) begin fails++; $display("[TB] FAIL strobe_0101: rdata=%h required 00bb00dd", d); end
    write_word(32'h8000_0200, 32'h11FF_FFFF, 4'b1000);
    send_ar(32'h8000_0200, 8'd0);
    recv_r(d, resp, last);
    checks++; if (d !== 32'h11BB_00DD) begin fails++; $display("[TB] FAIL strobe_1000: rdata=%h required 11bb00dd", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] resp; logic last;
    send_aw(32'h8000_0300, 8'd3);
    for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i), 4'hF, i == 3);
    recv_b(resp);
    send_ar(32'h8000_0300, 8'd3);
    recv_r(d, resp, last);
    recv_r(d, resp, last);
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA2 || bus.rlast !== 1'b0) begin fails++; $display("[TB] FAIL bp_hold%0d: rvalid=%b rdata=%h rlast=%b required 1 a2 0", c, bus.rvalid, bus.rdata, bus.rlast); end
      tick();
    end
    recv_r(d, resp, last);
    checks++; if (d !== 32'hA2 || last !== 1'b0) begin fails++; $display("[TB] FAIL bp_beat2: rdata=%h rlast=%b required a2 0", d, last); end
    recv_r(d, resp, last);
    checks++; if (d !== 32'hA3 || last !== 1'b1) begin fails++; $display("[TB] FAIL bp_beat3: rdata=%h rlast=%b required a3 1", d, last); end
    send_aw(32'h8000_0400, 8'd0);
    send_w(32'h5A5A_5A5A, 4'hF, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.bvalid !== 1'b1) begin fails++; $display("[TB] FAIL bp_bvalid%0d: bvalid=%b required 1", c, bus.bvalid); end
      tick();
    end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    checks++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin fails++; $display("[TB] FAIL bp_bdone: bvalid=%b awready=%b required 0 1", bus.bvalid, bus.awready); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] resp; logic last;
    send_ar(32'h7FFF_FFFC, 8'd0);
    recv_r(d, resp, last);
    checks++; if (resp !== 2'b10 || d !== 32'hdead_beef || last !== 1'b1) begin fails++; $display("[TB] FAIL oor_read: rresp=%b rdata=%h rlast=%b required 10 deadbeef 1", resp, d, last); end
    write_word(32'h8003_FFFC, 32'hCAFE_0001, 4'hF);
    send_aw(32'h7FFF_FFFC, 8'd0);
    send_w(32'h5555_5555, 4'hF, 1'b1);
    recv_b(resp);
    checks++; if (resp !== 2'b10) begin fails++; $display("[TB] FAIL oor_bresp: got %b required 10", resp); end
    send_ar(32'h8003_FFFC, 8'd1);
    recv_r(d, resp, last);
    checks++; if (d !== 32'hCAFE_0001 || resp !== 2'b00 || last !== 1'b0) begin fails++; $display("[TB] FAIL edge_beat0: rdata=%h rresp=%b rlast=%b required cafe0001 00 0", d, resp, last); end
    recv_r(d, resp, last);
    checks++; if (d !== 32'hdead_beef || resp !== 2'b10 || last !== 1'b1) begin fails++; $display("[TB] FAIL edge_beat1: rdata=%h rresp=%b rlast=%b required deadbeef 10 1", d, resp, last); end
    send_ar(32'h8000_0000, 8'd0);
    recv_r(d, resp, last);
    checks++; if (d !== 32'h1234_5678) begin fails++; $display("[TB] FAIL oor_nowrite: rdata=%h required 12345678", d); end
  endtask

  task automatic test_wlast_mismatch();
    logic [31:0] d; logic [1:0] resp; logic last;
    send_aw(32'h8000_0600, 8'd1);
    send_w(32'h11, 4'hF, 1'b1);
    send_w(32'h22, 4'hF, 1'b0);
    recv_b(resp);
    checks++; if (resp !== 2'b10) begin fails++; $display("[TB] FAIL wlast_bresp: got %b required 10", resp); end
    send_ar(32'h8000_0600, 8'd1);
    recv_r(d, resp, last);
    checks++; if (d !== 32'h11) begin fails++; $display("[TB] FAIL wlast_data0: rdata=%h required 11", d); end
    recv_r(d, resp, last);
    checks++; if (d !== 32'h22) begin fails++; $display("[TB] FAIL wlast_data1: rdata=%h required 22", d); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] d; logic [1:0] resp; logic last;
    write_word(32'h8000_0700, 32'h0101_0101, 4'hF);
    send_aw(32'h8000_0700, 8'd0);
    bus.wdata = 32'h0202_0202; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h8000_0700; bus.arlen = 8'd0; bus.arvalid = 1'b1;
    checks++; if (bus.wready !== 1'b1 || bus.arready !== 1'b1) begin fails++; $display("[TB] FAIL rbw_ready: wready=%b arready=%b required 1 1", bus.wready, bus.arready); end
    tick();
    bus.wvalid = 1'b0; bus.arvalid = 1'b0; bus.wlast = 1'b0;
    recv_r(d, resp, last);
    checks++; if (d !== 32'h0101_0101) begin fails++; $display("[TB] FAIL rbw_old: rdata=%h required 01010101", d); end
    recv_b(resp);
    send_ar(32'h8000_0700, 8'd0);
    recv_r(d, resp, last);
    checks++; if (d !== 32'h0202_0202) begin fails++; $display("[TB] FAIL rbw_new: rdata=%h required 02020202", d); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d; logic [1:0] resp; logic last;
    send_ar(32'h8000_0100, 8'd3);
    recv_r(d, resp, last);
    recv_r(d, resp, last);
    reset = 1'b0;
    tick();
    checks++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin fails++; $display("[TB] FAIL midreset_state: rvalid=%b arready=%b required 0 1", bus.rvalid, bus.arready); end
    reset = 1'b1;
    tick();
    send_ar(32'h8000_0104, 8'd0);
    recv_r(d, resp, last);
    checks++; if (d !== 32'd2 || resp !== 2'b00 || last !== 1'b1) begin fails++; $display("[TB] FAIL midreset_fresh: rdata=%h rresp=%b rlast=%b required 2 00 1", d, resp, last); end
  endtask

  initial begin
    bus.araddr = '0; bus.arvalid = 1'b0; bus.arlen = '0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.awlen = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.bready = 1'b0;
    test_reset();
    test_single_read();
    test_burst();
    test_strobe();
    test_backpressure();
    test_out_of_range();
    test_wlast_mismatch();
    test_read_before_write();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
